// File: rtl/instr_issue_unit.sv
// Program store and instruction sequencer feeding simple_cpu. A small
// program is written through the load port; after a start pulse each word is
// presented on `instruction` for as many cycles as its class needs, and issue
// stops at a HALT word or at the end of the store with a one-cycle done pulse.
module instr_issue_unit #(
  parameter int INSTR_WIDTH    = 20,
  parameter int PROG_ADDR_BITS = 4,
  parameter int ALU_CYCLES     = 3,
  parameter int LOAD_CYCLES    = 4,
  parameter int STORE_CYCLES   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prog_we,
  input  logic [PROG_ADDR_BITS-1:0] prog_addr,
  input  logic [INSTR_WIDTH-1:0]    prog_data,
  input  logic                      start,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      done
);

  localparam int DEPTH      = 1 << PROG_ADDR_BITS;
  localparam int MAX_AL     = (ALU_CYCLES > LOAD_CYCLES) ? ALU_CYCLES : LOAD_CYCLES;
  localparam int MAX_HOLD   = (MAX_AL > STORE_CYCLES) ? MAX_AL : STORE_CYCLES;
  localparam int CNT_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic [PROG_ADDR_BITS-1:0] LAST_ADDR    = PROG_ADDR_BITS'(DEPTH - 1);
  localparam logic [CNT_W-1:0]          ALU_RELOAD   = CNT_W'(ALU_CYCLES - 1);
  localparam logic [CNT_W-1:0]          LOAD_RELOAD  = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]          STORE_RELOAD = CNT_W'(STORE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [INSTR_WIDTH-1:0]      instr_q, instr_d;
  logic [PROG_ADDR_BITS-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic [INSTR_WIDTH-1:0]      mem [DEPTH];
  logic [PROG_ADDR_BITS-1:0]   pc_next;
  logic [INSTR_WIDTH-1:0]      first_word;
  logic [INSTR_WIDTH-1:0]      next_word;

  // Remaining-cycle count to load when a word of the given class is issued
  function automatic logic [CNT_W-1:0] reload_for(input logic [1:0] cls);
    case (cls)
      2'b10:   reload_for = LOAD_RELOAD;
      2'b11:   reload_for = STORE_RELOAD;
      default: reload_for = ALU_RELOAD;
    endcase
  endfunction

  assign pc_next    = pc_q + 1'b1;
  assign first_word = mem[0];
  assign next_word  = mem[pc_next];

  // Program store: written only outside ISSUE, never cleared by reset
  always_ff @(posedge clk) begin
    if (prog_we && (state_q != ISSUE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Sequencer registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: start, count down each hold, advance or finish
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (first_word[INSTR_WIDTH-1 -: 2] == 2'b00) begin
            state_d = DONE;
          end else begin
            pc_d    = '0;
            instr_d = first_word;
            cnt_d   = reload_for(first_word[INSTR_WIDTH-1 -: 2]);
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if ((pc_q == LAST_ADDR) || (next_word[INSTR_WIDTH-1 -: 2] == 2'b00)) begin
          instr_d = '0;
          state_d = DONE;
        end else begin
          pc_d    = pc_next;
          instr_d = next_word;
          cnt_d   = reload_for(next_word[INSTR_WIDTH-1 -: 2]);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign busy        = (state_q == ISSUE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_instr_issue_unit.sv
// Self-checking bench for instr_issue_unit: directed programs from the test
// plan plus randomized programs, compared cycle by cycle against a schedule
// built from the issue rules (hold counts per class, HALT/end-of-store stop).
module tb_instr_issue_unit;

   logic        clk;
   logic        rst;
   logic        progWe;
   logic [3:0]  progAddr;
   logic [19:0] progData;
   logic        start;
   logic [19:0] instruction;
   logic [3:0]  pc;
   logic        busy;
   logic        done;

   int assertCount;
   int failCount;

   typedef struct {
      logic [19:0] instr;
      logic [3:0]  pc;
      logic        busy;
      logic        done;
   } expEntry;

   logic [19:0] modelMem [16];
   logic [3:0]  modelPc;
   expEntry     expQ [$];

   instr_issue_unit dut (
      .clk         (clk),
      .rst         (rst),
      .prog_we     (progWe),
      .prog_addr   (progAddr),
      .prog_data   (progData),
      .start       (start),
      .instruction (instruction),
      .pc          (pc),
      .busy        (busy),
      .done        (done)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: count it and report any disagreement
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   function automatic int holdOf(input logic [19:0] w);
      case (w[19:18])
         2'b01:   return 3;
         2'b10:   return 4;
         2'b11:   return 3;
         default: return 0;
      endcase
   endfunction

   // Expected per-cycle outputs after each edge, starting at the start edge
   task automatic buildSchedule();
      int a;
      expEntry e;
      expQ.delete();
      if (modelMem[0][19:18] == 2'b00) begin
         e = '{instr: 20'h0, pc: modelPc, busy: 1'b0, done: 1'b1};
         expQ.push_back(e);
      end else begin
         a = 0;
         forever begin
            for (int h = 0; h < holdOf(modelMem[a]); h++) begin
               e = '{instr: modelMem[a], pc: 4'(a), busy: 1'b1, done: 1'b0};
               expQ.push_back(e);
            end
            if (a == 15) break;
            if (modelMem[a+1][19:18] == 2'b00) break;
            a++;
         end
         modelPc = 4'(a);
         e = '{instr: 20'h0, pc: modelPc, busy: 1'b0, done: 1'b1};
         expQ.push_back(e);
      end
      e = '{instr: 20'h0, pc: modelPc, busy: 1'b0, done: 1'b0};
      expQ.push_back(e);
   endtask

   task automatic checkEntry(input int i);
      checkOutput($sformatf("instr[%0d]", i), 32'(instruction), 32'(expQ[i].instr));
      checkOutput($sformatf("pc[%0d]", i),    32'(pc),          32'(expQ[i].pc));
      checkOutput($sformatf("busy[%0d]", i),  32'(busy),        32'(expQ[i].busy));
      checkOutput($sformatf("done[%0d]", i),  32'(done),        32'(expQ[i].done));
   endtask

   // Write all sixteen store words through the load port while idle
   task automatic loadProgram(input logic [19:0] words [16]);
      for (int a = 0; a < 16; a++) begin
         progWe   = 1'b1;
         progAddr = 4'(a);
         progData = words[a];
         @(posedge clk); #1;
         modelMem[a] = words[a];
      end
      progWe = 1'b0;
   endtask

   // Pulse start and follow the whole run; optionally inject an ignored
   // write/start while busy, or a write to address 0 alongside start
   task automatic applyStimulus(input int injectAt, input bit startWrite, input logic [19:0] startData);
      buildSchedule();
      start = 1'b1;
      if (startWrite) begin
         progWe   = 1'b1;
         progAddr = 4'd0;
         progData = startData;
      end
      for (int i = 0; i < expQ.size(); i++) begin
         @(posedge clk); #1;
         if (i == 0 && startWrite) modelMem[0] = startData;
         start  = 1'b0;
         progWe = 1'b0;
         checkEntry(i);
         if (i == injectAt && expQ[i].busy) begin
            progWe   = 1'b1;
            progAddr = 4'd1;
            progData = 20'h00000;
            start    = 1'b1;
         end
      end
      start  = 1'b0;
      progWe = 1'b0;
   endtask

   // Reset asserted mid-hold of the second word: outputs clear at once
   task automatic resetMidRun();
      buildSchedule();
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         checkEntry(i);
      end
      #2 rst = 1'b0;
      #1;
      checkOutput("rstInstr", 32'(instruction), 32'h0);
      checkOutput("rstPc",    32'(pc),          32'h0);
      checkOutput("rstBusy",  32'(busy),        32'h0);
      checkOutput("rstDone",  32'(done),        32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      modelPc = 4'd0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("postRstDone[%0d]", i), 32'(done), 32'h0);
         checkOutput($sformatf("postRstBusy[%0d]", i), 32'(busy), 32'h0);
      end
   endtask

   initial begin
      logic [19:0] prog [16];
      logic [19:0] w;
      int len;
      int inject;

      assertCount = 0;
      failCount   = 0;
      rst      = 1'b0;
      progWe   = 1'b0;
      progAddr = 4'd0;
      progData = 20'h0;
      start    = 1'b0;
      modelPc  = 4'd0;

      #2;
      checkOutput("resetInstr", 32'(instruction), 32'h0);
      checkOutput("resetPc",    32'(pc),          32'h0);
      checkOutput("resetBusy",  32'(busy),        32'h0);
      checkOutput("resetDone",  32'(done),        32'h0);
      @(posedge clk); #1;
      rst = 1'b1;

      $display("[TB] ALU sequence");
      foreach (prog[a]) prog[a] = 20'h0;
      prog[0] = 20'h47000; prog[1] = 20'h53000; prog[2] = 20'h72001;
      loadProgram(prog);
      applyStimulus(-1, 1'b0, 20'h0);

      $display("[TB] Ignored inputs while busy");
      applyStimulus(4, 1'b0, 20'h0);
      applyStimulus(-1, 1'b0, 20'h0);

      $display("[TB] Async reset mid-run");
      resetMidRun();
      applyStimulus(-1, 1'b0, 20'h0);

      $display("[TB] Memory classes");
      foreach (prog[a]) prog[a] = 20'h0;
      prog[0] = 20'hD80F0; prog[1] = 20'hB80F0;
      loadProgram(prog);
      applyStimulus(-1, 1'b0, 20'h0);

      $display("[TB] Empty program and write alongside start");
      foreach (prog[a]) prog[a] = 20'h0;
      loadProgram(prog);
      applyStimulus(-1, 1'b0, 20'h0);
      applyStimulus(-1, 1'b1, 20'h47000);
      applyStimulus(-1, 1'b0, 20'h0);

      $display("[TB] Full store");
      foreach (prog[a]) prog[a] = 20'h47000;
      loadProgram(prog);
      applyStimulus(-1, 1'b0, 20'h0);
      repeat (3) @(posedge clk);
      #1 checkOutput("pcIdleHold", 32'(pc), 32'd15);

      $display("[TB] Randomized programs");
      for (int r = 0; r < 12; r++) begin
         len = $urandom_range(0, 16);
         for (int a = 0; a < 16; a++) begin
            w = 20'($urandom);
            if (a < len) begin
               w[19:18] = 2'($urandom_range(1, 3));
            end else if (a == len) begin
               w[19:18] = 2'b00;
            end
            prog[a] = w;
         end
         loadProgram(prog);
         inject = (len > 0) ? int'($urandom_range(0, 2)) : -1;
         applyStimulus(inject, 1'b0, 20'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
